// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand-B source encodings used by the operand
// stage and by the control unit that drives its sel input.
package alu_pkg;

    localparam int OPB_SEL_W = 3;

    localparam logic [OPB_SEL_W-1:0] OPB_SRC0       = 3'd0;
    localparam logic [OPB_SEL_W-1:0] OPB_CONST      = 3'd1;
    localparam logic [OPB_SEL_W-1:0] OPB_SRC1       = 3'd2;
    localparam logic [OPB_SEL_W-1:0] OPB_SRC2       = 3'd3;
    localparam logic [OPB_SEL_W-1:0] OPB_NOT_SRC0   = 3'd4;
    localparam logic [OPB_SEL_W-1:0] OPB_IMM_SX     = 3'd5;
    localparam logic [OPB_SEL_W-1:0] OPB_IMM_SX_SH2 = 3'd6;
    localparam logic [OPB_SEL_W-1:0] OPB_IMM_ZX     = 3'd7;

endpackage

// File: rtl/opb_select.sv
// Operand-B selector/extender: purely combinational choice between the
// datapath sources, the PC-increment constant and the extended immediate.
module opb_select
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic [OPB_SEL_W-1:0] sel,
    input  logic [WIDTH-1:0]     src0,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic [WIDTH-1:0]     const_inc,
    input  logic [IMM_W-1:0]     imm,
    output logic [WIDTH-1:0]     operand
);

    logic [WIDTH-1:0] imm_sx;
    logic [WIDTH-1:0] imm_zx;

    // Sign- and zero-extended forms of the immediate
    always_comb begin
        imm_sx = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        imm_zx = {{(WIDTH-IMM_W){1'b0}}, imm};
    end

    // Decode every sel code; the shifted form drops the bits pushed off the top
    always_comb begin
        operand = src0;
        case (sel)
            OPB_SRC0:       operand = src0;
            OPB_CONST:      operand = const_inc;
            OPB_SRC1:       operand = src1;
            OPB_SRC2:       operand = src2;
            OPB_NOT_SRC0:   operand = ~src0;
            OPB_IMM_SX:     operand = imm_sx;
            OPB_IMM_SX_SH2: operand = imm_sx << 2;
            OPB_IMM_ZX:     operand = imm_zx;
        endcase
    end

endmodule

// File: rtl/alu_operand_b_stage.sv
// Operand-B pipeline stage: selects operand B and holds it in an output
// register backed by a one-entry skid register, so in_ready never depends
// combinationally on out_ready.
module alu_operand_b_stage
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int CONST_INC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPB_SEL_W-1:0] sel,
    input  logic [WIDTH-1:0]     src0,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    input  logic [IMM_W-1:0]     imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data
);

    localparam logic [WIDTH-1:0] CONST_VAL = WIDTH'(CONST_INC);

    logic [WIDTH-1:0] sel_operand;
    logic             accept;
    logic             out_free;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    opb_select #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W)
    ) u_opb_select (
        .sel       (sel),
        .src0      (src0),
        .src1      (src1),
        .src2      (src2),
        .const_inc (CONST_VAL),
        .imm       (imm),
        .operand   (sel_operand)
    );

    // Handshake terms: ready only while reset is released and the skid is empty
    always_comb begin
        in_ready = ~reset & ~skid_valid_q;
        accept   = in_valid & in_ready;
        out_free = ~out_valid_q | out_ready;
    end

    // Next-state for the output and skid registers; flush overrides everything
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_operand;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_operand;
        end
    end

    // State registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

endmodule
